// File: rtl/fsm_ascon128_pkg.sv
// Shared types and round-counter constants for the ASCON-128 sequencer.
package ascon_pkg;

   typedef enum logic [4:0] {
      IDLE,
      CONF_INIT,
      INIT_RD0,
      INIT_RUN,
      INIT_LAST,
      AD_WAIT,
      AD_RD0,
      AD_RUN,
      AD_LAST,
      PT_WAIT,
      PT_RD0,
      PT_RUN,
      PT_LAST,
      FIN_RD0,
      FIN_RUN,
      FIN_LAST,
      DONE
   } state_t;

   localparam logic [3:0] P12_FIRST     = 4'd0;
   localparam logic [3:0] P6_FIRST      = 4'd6;
   localparam logic [3:0] ROUND_PRELAST = 4'd10;
   localparam logic [3:0] ROUND_LAST    = 4'd11;

endpackage

// File: rtl/fsm_ascon128_if.sv
// Block handshake and status signals between the data source and the sequencer.
interface fsm_ascon128_if;

   logic start_i;
   logic data_valid_i;
   logic last_block_i;
   logic data_ready_o;
   logic busy_o;
   logic end_o;

   modport master (
      output start_i, data_valid_i, last_block_i,
      input  data_ready_o, busy_o, end_o
   );

   modport slave (
      input  start_i, data_valid_i, last_block_i,
      output data_ready_o, busy_o, end_o
   );

endinterface

// File: rtl/fsm_ascon128.sv
// ASCON-128 encryption sequencer: steps init, AD, PT and finalisation, driving the
// external round counter, state-register enable and the datapath XOR injection points.
module fsm_ascon128
   import ascon_pkg::*;
(
   input  logic           clock_i,
   input  logic           resetb_i,
   fsm_ascon128_if.slave  hs,
   input  logic [3:0]     round_i,
   output logic           en_cpt_perm_o,
   output logic           init_p12_o,
   output logic           init_p6_o,
   output logic           input_mode_o,
   output logic           en_reg_state_o,
   output logic           en_xor_data_o,
   output logic           en_xor_key_begin_o,
   output logic           en_xor_key_end_o,
   output logic           en_xor_lsb_o,
   output logic           en_cipher_o,
   output logic           en_tag_o
);

   // state      | meaning
   // IDLE       | waiting for start_i
   // CONF_INIT  | load round counter for the 12-round init permutation
   // *_WAIT     | AD / PT block handshake, counter preload
   // *_RD0      | first round of a phase, data / key injection
   // *_RUN      | middle rounds until round_i reaches 10
   // *_LAST     | final round with phase-specific XORs
   // DONE       | one-cycle completion pulse

   state_t state, state_n;
   logic   last_q;
   logic   data_ready;
   logic   end_pulse;

   always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) begin
         state  <= IDLE;
         last_q <= 1'b0;
      end else begin
         state <= state_n;
         if (state == AD_WAIT && hs.data_valid_i)
            last_q <= hs.last_block_i;
      end
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:      if (hs.start_i) state_n = CONF_INIT;
         CONF_INIT: state_n = INIT_RD0;
         INIT_RD0:  state_n = INIT_RUN;
         INIT_RUN:  if (round_i == ROUND_PRELAST) state_n = INIT_LAST;
         INIT_LAST: state_n = AD_WAIT;
         AD_WAIT:   if (hs.data_valid_i) state_n = AD_RD0;
         AD_RD0:    state_n = AD_RUN;
         AD_RUN:    if (round_i == ROUND_PRELAST) state_n = AD_LAST;
         AD_LAST:   state_n = last_q ? PT_WAIT : AD_WAIT;
         PT_WAIT:   if (hs.data_valid_i) state_n = hs.last_block_i ? FIN_RD0 : PT_RD0;
         PT_RD0:    state_n = PT_RUN;
         PT_RUN:    if (round_i == ROUND_PRELAST) state_n = PT_LAST;
         PT_LAST:   state_n = PT_WAIT;
         FIN_RD0:   state_n = FIN_RUN;
         FIN_RUN:   if (round_i == ROUND_PRELAST) state_n = FIN_LAST;
         FIN_LAST:  state_n = DONE;
         DONE:      state_n = IDLE;
         default:   state_n = IDLE;
      endcase
   end

   always_comb begin
      data_ready         = 1'b0;
      end_pulse          = 1'b0;
      en_cpt_perm_o      = 1'b0;
      init_p12_o         = 1'b0;
      init_p6_o          = 1'b0;
      input_mode_o       = 1'b0;
      en_reg_state_o     = 1'b0;
      en_xor_data_o      = 1'b0;
      en_xor_key_begin_o = 1'b0;
      en_xor_key_end_o   = 1'b0;
      en_xor_lsb_o       = 1'b0;
      en_cipher_o        = 1'b0;
      en_tag_o           = 1'b0;
      case (state)
         CONF_INIT: begin
            en_cpt_perm_o = 1'b1;
            init_p12_o    = 1'b1;
         end
         INIT_RD0: begin
            en_cpt_perm_o  = 1'b1;
            en_reg_state_o = 1'b1;
         end
         INIT_RUN, AD_RUN, PT_RUN, FIN_RUN: begin
            en_cpt_perm_o  = 1'b1;
            en_reg_state_o = 1'b1;
            input_mode_o   = 1'b1;
         end
         INIT_LAST: begin
            en_reg_state_o   = 1'b1;
            input_mode_o     = 1'b1;
            en_xor_key_end_o = 1'b1;
         end
         AD_WAIT: begin
            if (hs.data_valid_i) begin
               data_ready    = 1'b1;
               en_cpt_perm_o = 1'b1;
               init_p6_o     = 1'b1;
            end
         end
         AD_RD0, PT_RD0: begin
            en_cpt_perm_o  = 1'b1;
            en_reg_state_o = 1'b1;
            input_mode_o   = 1'b1;
            en_xor_data_o  = 1'b1;
         end
         AD_LAST: begin
            en_reg_state_o = 1'b1;
            input_mode_o   = 1'b1;
            en_xor_lsb_o   = last_q;
         end
         PT_WAIT: begin
            if (hs.data_valid_i) begin
               data_ready    = 1'b1;
               en_cipher_o   = 1'b1;
               en_cpt_perm_o = 1'b1;
               init_p6_o     = !hs.last_block_i;
               init_p12_o    = hs.last_block_i;
            end
         end
         PT_LAST: begin
            en_reg_state_o = 1'b1;
            input_mode_o   = 1'b1;
         end
         FIN_RD0: begin
            en_cpt_perm_o      = 1'b1;
            en_reg_state_o     = 1'b1;
            input_mode_o       = 1'b1;
            en_xor_data_o      = 1'b1;
            en_xor_key_begin_o = 1'b1;
         end
         FIN_LAST: begin
            en_reg_state_o   = 1'b1;
            input_mode_o     = 1'b1;
            en_xor_key_end_o = 1'b1;
            en_tag_o         = 1'b1;
         end
         DONE:    end_pulse = 1'b1;
         default: ;
      endcase
   end

   assign hs.data_ready_o = data_ready;
   assign hs.end_o        = end_pulse;
   assign hs.busy_o       = (state != IDLE);

endmodule
